// File: rtl/store_drain_unit.sv
// Drains committed stores from the store-queue head into the dcache, one entry in flight.
// A missed write is replayed from the holding register after a fixed idle backoff.
//
// state   | meaning
// IDLE    | no entry held, head entry may be accepted
// REQ     | write request presented to dcache from holding register
// WAIT    | request accepted, waiting for dcache response
// BACKOFF | miss seen, idling before replaying the same request
module store_drain_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int QUEUE_SIZE     = 8,
    parameter int BACKOFF_CYCLES = 4,
    parameter int ID_WIDTH       = $clog2(QUEUE_SIZE)
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    sq_valid_i,
    output logic                    sq_ready_o,
    input  logic [ADDR_WIDTH-1:0]   sq_addr_i,
    input  logic [DATA_WIDTH-1:0]   sq_data_i,
    input  logic [DATA_WIDTH/8-1:0] sq_wstrb_i,
    input  logic [ID_WIDTH-1:0]     sq_id_i,
    input  logic                    sq_uncached_i,

    output logic                    dc_req_valid_o,
    input  logic                    dc_req_ready_i,
    output logic [ADDR_WIDTH-1:0]   dc_addr_o,
    output logic [DATA_WIDTH-1:0]   dc_data_o,
    output logic [DATA_WIDTH/8-1:0] dc_wstrb_o,
    output logic                    dc_uncached_o,
    input  logic                    dc_resp_valid_i,
    input  logic                    dc_resp_miss_i,

    output logic                    retire_valid_o,
    output logic [ID_WIDTH-1:0]     retire_id_o,
    output logic                    busy_o,
    output logic [15:0]             replay_cnt_o
);

    localparam int BO_WIDTH = (BACKOFF_CYCLES > 1) ? $clog2(BACKOFF_CYCLES) : 1;
    localparam logic [BO_WIDTH-1:0] BO_LOAD = BO_WIDTH'(BACKOFF_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_WAIT    = 2'd2,
        ST_BACKOFF = 2'd3
    } state_t;

    state_t                  state;
    logic [BO_WIDTH-1:0]     bo_cnt;
    logic [ADDR_WIDTH-1:0]   hold_addr;
    logic [DATA_WIDTH-1:0]   hold_data;
    logic [DATA_WIDTH/8-1:0] hold_wstrb;
    logic [ID_WIDTH-1:0]     hold_id;
    logic                    hold_uncached;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            bo_cnt         <= '0;
            hold_addr      <= '0;
            hold_data      <= '0;
            hold_wstrb     <= '0;
            hold_id        <= '0;
            hold_uncached  <= 1'b0;
            retire_valid_o <= 1'b0;
            retire_id_o    <= '0;
            replay_cnt_o   <= '0;
        end else begin
            retire_valid_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (sq_valid_i) begin
                        hold_addr     <= sq_addr_i;
                        hold_data     <= sq_data_i;
                        hold_wstrb    <= sq_wstrb_i;
                        hold_id       <= sq_id_i;
                        hold_uncached <= sq_uncached_i;
                        // an all-zero strobe writes nothing, so retire without touching the dcache
                        if (sq_wstrb_i != '0) begin
                            state <= ST_REQ;
                        end else begin
                            retire_valid_o <= 1'b1;
                            retire_id_o    <= sq_id_i;
                        end
                    end
                end
                ST_REQ: begin
                    if (dc_req_ready_i) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (dc_resp_valid_i) begin
                        if (dc_resp_miss_i) begin
                            state  <= ST_BACKOFF;
                            bo_cnt <= BO_LOAD;
                            if (replay_cnt_o != 16'hFFFF) begin
                                replay_cnt_o <= replay_cnt_o + 16'd1;
                            end
                        end else begin
                            state          <= ST_IDLE;
                            retire_valid_o <= 1'b1;
                            retire_id_o    <= hold_id;
                        end
                    end
                end
                ST_BACKOFF: begin
                    if (bo_cnt == '0) begin
                        state <= ST_REQ;
                    end else begin
                        bo_cnt <= bo_cnt - BO_WIDTH'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign sq_ready_o     = (state == ST_IDLE);
    assign busy_o         = (state != ST_IDLE);
    assign dc_req_valid_o = (state == ST_REQ);
    assign dc_addr_o      = hold_addr;
    assign dc_data_o      = hold_data;
    assign dc_wstrb_o     = hold_wstrb;
    assign dc_uncached_o  = hold_uncached;

endmodule

// File: tb/tb_store_drain_unit.sv
// Directed bench for store_drain_unit: reset, drain, backpressure, replay,
// zero strobe, reset mid-transaction and back-to-back retire ordering.
module tb_store_drain_unit;

    logic        clk;
    logic        rst;
    logic        sq_valid_i;
    logic        sq_ready_o;
    logic [31:0] sq_addr_i;
    logic [31:0] sq_data_i;
    logic [3:0]  sq_wstrb_i;
    logic [2:0]  sq_id_i;
    logic        sq_uncached_i;
    logic        dc_req_valid_o;
    logic        dc_req_ready_i;
    logic [31:0] dc_addr_o;
    logic [31:0] dc_data_o;
    logic [3:0]  dc_wstrb_o;
    logic        dc_uncached_o;
    logic        dc_resp_valid_i;
    logic        dc_resp_miss_i;
    logic        retire_valid_o;
    logic [2:0]  retire_id_o;
    logic        busy_o;
    logic [15:0] replay_cnt_o;

    int pass_cnt = 0;
    int total_cnt = 0;
    int retire_seen = 0;

    store_drain_unit #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .QUEUE_SIZE(8), .BACKOFF_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst),
        .sq_valid_i(sq_valid_i), .sq_ready_o(sq_ready_o),
        .sq_addr_i(sq_addr_i), .sq_data_i(sq_data_i), .sq_wstrb_i(sq_wstrb_i),
        .sq_id_i(sq_id_i), .sq_uncached_i(sq_uncached_i),
        .dc_req_valid_o(dc_req_valid_o), .dc_req_ready_i(dc_req_ready_i),
        .dc_addr_o(dc_addr_o), .dc_data_o(dc_data_o), .dc_wstrb_o(dc_wstrb_o),
        .dc_uncached_o(dc_uncached_o),
        .dc_resp_valid_i(dc_resp_valid_i), .dc_resp_miss_i(dc_resp_miss_i),
        .retire_valid_o(retire_valid_o), .retire_id_o(retire_id_o),
        .busy_o(busy_o), .replay_cnt_o(replay_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mid-cycle pulse counter, used to prove exactly one retire per acceptance
    always @(negedge clk) if (retire_valid_o === 1'b1) retire_seen++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [2:0] id, input logic unc);
        sq_valid_i = 1'b1; sq_addr_i = a; sq_data_i = d;
        sq_wstrb_i = s; sq_id_i = id; sq_uncached_i = unc;
    endtask

    task automatic test_reset();
        tick();
        total_cnt++; if (sq_ready_o !== 1'b1) $display("FAIL rst_sq_ready got %b exp 1", sq_ready_o); else pass_cnt++;
        total_cnt++; if (dc_req_valid_o !== 1'b0) $display("FAIL rst_req_valid got %b exp 0", dc_req_valid_o); else pass_cnt++;
        total_cnt++; if (retire_valid_o !== 1'b0) $display("FAIL rst_retire_valid got %b exp 0", retire_valid_o); else pass_cnt++;
        total_cnt++; if (retire_id_o !== 3'd0) $display("FAIL rst_retire_id got %0d exp 0", retire_id_o); else pass_cnt++;
        total_cnt++; if (busy_o !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy_o); else pass_cnt++;
        total_cnt++; if (replay_cnt_o !== 16'd0) $display("FAIL rst_replay got %0d exp 0", replay_cnt_o); else pass_cnt++;
        total_cnt++; if (dc_addr_o !== 32'd0 || dc_wstrb_o !== 4'd0) $display("FAIL rst_hold got %h/%h exp 0/0", dc_addr_o, dc_wstrb_o); else pass_cnt++;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int r0;
        r0 = retire_seen;
        present(32'h1000, 32'hDEADBEEF, 4'hF, 3'd3, 1'b0);
        dc_req_ready_i = 1'b1;
        total_cnt++; if (sq_ready_o !== 1'b1) $display("FAIL basic_accept got %b exp 1", sq_ready_o); else pass_cnt++;
        tick();
        sq_valid_i = 1'b0;
        total_cnt++; if (dc_req_valid_o !== 1'b1) $display("FAIL basic_req_valid got %b exp 1", dc_req_valid_o); else pass_cnt++;
        total_cnt++; if (dc_addr_o !== 32'h1000 || dc_data_o !== 32'hDEADBEEF || dc_wstrb_o !== 4'hF)
            $display("FAIL basic_fields got %h %h %h exp 1000 deadbeef f", dc_addr_o, dc_data_o, dc_wstrb_o); else pass_cnt++;
        total_cnt++; if (sq_ready_o !== 1'b0 || busy_o !== 1'b1) $display("FAIL basic_busy got rdy %b busy %b exp 0 1", sq_ready_o, busy_o); else pass_cnt++;
        tick();
        dc_resp_valid_i = 1'b1; dc_resp_miss_i = 1'b0;
        total_cnt++; if (dc_req_valid_o !== 1'b0) $display("FAIL basic_wait_req got %b exp 0", dc_req_valid_o); else pass_cnt++;
        tick();
        dc_resp_valid_i = 1'b0; dc_req_ready_i = 1'b0;
        total_cnt++; if (retire_valid_o !== 1'b1 || retire_id_o !== 3'd3) $display("FAIL basic_retire got %b id %0d exp 1 id 3", retire_valid_o, retire_id_o); else pass_cnt++;
        total_cnt++; if (sq_ready_o !== 1'b1) $display("FAIL basic_idle_again got %b exp 1", sq_ready_o); else pass_cnt++;
        tick();
        total_cnt++; if (retire_valid_o !== 1'b0) $display("FAIL basic_single_pulse got %b exp 0", retire_valid_o); else pass_cnt++;
        total_cnt++; if (retire_seen - r0 !== 1) $display("FAIL basic_retire_count got %0d exp 1", retire_seen - r0); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int held;
        held = 0;
        present(32'h2000, 32'h12345678, 4'b0011, 3'd1, 1'b1);
        dc_req_ready_i = 1'b0;
        tick();
        // a different head entry is waiting: it must not be taken while busy
        present(32'h9999, 32'h0, 4'hF, 3'd7, 1'b0);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) dc_req_ready_i = 1'b1;
            if (dc_req_valid_o === 1'b1) held++;
            total_cnt++; if (dc_addr_o !== 32'h2000 || dc_data_o !== 32'h12345678 || dc_wstrb_o !== 4'b0011 || dc_uncached_o !== 1'b1)
                $display("FAIL bp_fields cyc %0d got %h %h %h %b exp 2000 12345678 3 1", i, dc_addr_o, dc_data_o, dc_wstrb_o, dc_uncached_o); else pass_cnt++;
            total_cnt++; if (sq_ready_o !== 1'b0) $display("FAIL bp_sq_ready cyc %0d got %b exp 0", i, sq_ready_o); else pass_cnt++;
            tick();
        end
        sq_valid_i = 1'b0; dc_req_ready_i = 1'b0;
        total_cnt++; if (held !== 6) $display("FAIL bp_held_cycles got %0d exp 6", held); else pass_cnt++;
        total_cnt++; if (dc_req_valid_o !== 1'b0) $display("FAIL bp_wait_req got %b exp 0", dc_req_valid_o); else pass_cnt++;
        dc_resp_valid_i = 1'b1; dc_resp_miss_i = 1'b0;
        tick();
        dc_resp_valid_i = 1'b0;
        total_cnt++; if (retire_valid_o !== 1'b1 || retire_id_o !== 3'd1) $display("FAIL bp_retire got %b id %0d exp 1 id 1", retire_valid_o, retire_id_o); else pass_cnt++;
        tick();
    endtask

    task automatic test_replay();
        int gap;
        int r0;
        gap = 0;
        r0 = retire_seen;
        present(32'h3000, 32'hCAFEF00D, 4'hF, 3'd2, 1'b0);
        dc_req_ready_i = 1'b1;
        tick();
        sq_valid_i = 1'b0;
        total_cnt++; if (dc_req_valid_o !== 1'b1) $display("FAIL replay_first_req got %b exp 1", dc_req_valid_o); else pass_cnt++;
        tick();
        dc_resp_valid_i = 1'b1; dc_resp_miss_i = 1'b1;
        tick();
        // stray hit responses during backoff must be ignored
        dc_resp_miss_i = 1'b0;
        total_cnt++; if (replay_cnt_o !== 16'd1) $display("FAIL replay_cnt got %0d exp 1", replay_cnt_o); else pass_cnt++;
        while (dc_req_valid_o !== 1'b1 && gap < 20) begin
            if (retire_valid_o === 1'b1) gap = 100;
            gap++;
            tick();
        end
        dc_resp_valid_i = 1'b0;
        total_cnt++; if (gap !== 4) $display("FAIL replay_gap got %0d exp 4", gap); else pass_cnt++;
        total_cnt++; if (dc_addr_o !== 32'h3000 || dc_data_o !== 32'hCAFEF00D || dc_wstrb_o !== 4'hF)
            $display("FAIL replay_fields got %h %h %h exp 3000 cafef00d f", dc_addr_o, dc_data_o, dc_wstrb_o); else pass_cnt++;
        tick();
        dc_resp_valid_i = 1'b1;
        tick();
        dc_resp_valid_i = 1'b0; dc_req_ready_i = 1'b0;
        total_cnt++; if (retire_valid_o !== 1'b1 || retire_id_o !== 3'd2) $display("FAIL replay_retire got %b id %0d exp 1 id 2", retire_valid_o, retire_id_o); else pass_cnt++;
        tick();
        total_cnt++; if (retire_seen - r0 !== 1) $display("FAIL replay_retire_count got %0d exp 1", retire_seen - r0); else pass_cnt++;
        total_cnt++; if (replay_cnt_o !== 16'd1) $display("FAIL replay_cnt_final got %0d exp 1", replay_cnt_o); else pass_cnt++;
    endtask

    task automatic test_zero_strobe();
        present(32'h5000, 32'h55555555, 4'h0, 3'd5, 1'b0);
        tick();
        sq_valid_i = 1'b0;
        total_cnt++; if (retire_valid_o !== 1'b1 || retire_id_o !== 3'd5) $display("FAIL zs_retire got %b id %0d exp 1 id 5", retire_valid_o, retire_id_o); else pass_cnt++;
        total_cnt++; if (sq_ready_o !== 1'b1 || busy_o !== 1'b0) $display("FAIL zs_idle got rdy %b busy %b exp 1 0", sq_ready_o, busy_o); else pass_cnt++;
        total_cnt++; if (dc_req_valid_o !== 1'b0) $display("FAIL zs_no_req got %b exp 0", dc_req_valid_o); else pass_cnt++;
        tick();
        total_cnt++; if (retire_valid_o !== 1'b0 || dc_req_valid_o !== 1'b0) $display("FAIL zs_after got ret %b req %b exp 0 0", retire_valid_o, dc_req_valid_o); else pass_cnt++;
    endtask

    task automatic test_reset_mid_wait();
        int r0;
        r0 = retire_seen;
        present(32'h6000, 32'h66666666, 4'hF, 3'd6, 1'b0);
        dc_req_ready_i = 1'b1;
        tick();
        sq_valid_i = 1'b0;
        tick();
        total_cnt++; if (busy_o !== 1'b1 || dc_req_valid_o !== 1'b0) $display("FAIL rmw_in_wait got busy %b req %b exp 1 0", busy_o, dc_req_valid_o); else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++; if (busy_o !== 1'b0 || sq_ready_o !== 1'b1 || replay_cnt_o !== 16'd0 || dc_addr_o !== 32'd0)
            $display("FAIL rmw_reset_vals got busy %b rdy %b replay %0d addr %h exp 0 1 0 0", busy_o, sq_ready_o, replay_cnt_o, dc_addr_o); else pass_cnt++;
        tick();
        rst = 1'b1;
        dc_resp_valid_i = 1'b1; dc_resp_miss_i = 1'b0;
        tick();
        dc_resp_valid_i = 1'b0;
        tick();
        total_cnt++; if (retire_seen - r0 !== 0) $display("FAIL rmw_no_retire got %0d exp 0", retire_seen - r0); else pass_cnt++;
        total_cnt++; if (busy_o !== 1'b0 || retire_id_o !== 3'd0) $display("FAIL rmw_idle got busy %b id %0d exp 0 0", busy_o, retire_id_o); else pass_cnt++;
        present(32'h7000, 32'h77777777, 4'hF, 3'd7, 1'b0);
        tick();
        sq_valid_i = 1'b0;
        total_cnt++; if (dc_req_valid_o !== 1'b1 || dc_addr_o !== 32'h7000) $display("FAIL rmw_new_req got %b %h exp 1 7000", dc_req_valid_o, dc_addr_o); else pass_cnt++;
        tick();
        dc_resp_valid_i = 1'b1;
        tick();
        dc_resp_valid_i = 1'b0; dc_req_ready_i = 1'b0;
        total_cnt++; if (retire_valid_o !== 1'b1 || retire_id_o !== 3'd7) $display("FAIL rmw_new_retire got %b id %0d exp 1 id 7", retire_valid_o, retire_id_o); else pass_cnt++;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [2:0] id;
        int r0;
        r0 = retire_seen;
        dc_req_ready_i = 1'b1; dc_resp_miss_i = 1'b0;
        for (int k = 0; k < 9; k++) begin
            id = 3'(k % 8);
            present(32'h4000 + 32'(k * 4), 32'h11111111 * 32'(k), 4'hF, id, 1'b0);
            total_cnt++; if (sq_ready_o !== 1'b1) $display("FAIL b2b_accept k %0d got %b exp 1", k, sq_ready_o); else pass_cnt++;
            if (k > 0) begin
                total_cnt++; if (retire_valid_o !== 1'b1 || retire_id_o !== 3'((k - 1) % 8))
                    $display("FAIL b2b_retire k %0d got %b id %0d exp 1 id %0d", k, retire_valid_o, retire_id_o, (k - 1) % 8); else pass_cnt++;
            end
            tick();
            sq_valid_i = 1'b0;
            total_cnt++; if (dc_req_valid_o !== 1'b1 || dc_addr_o !== 32'h4000 + 32'(k * 4))
                $display("FAIL b2b_req k %0d got %b %h exp 1 %h", k, dc_req_valid_o, dc_addr_o, 32'h4000 + 32'(k * 4)); else pass_cnt++;
            tick();
            dc_resp_valid_i = 1'b1;
            tick();
            dc_resp_valid_i = 1'b0;
        end
        total_cnt++; if (retire_valid_o !== 1'b1 || retire_id_o !== 3'd0) $display("FAIL b2b_last_retire got %b id %0d exp 1 id 0", retire_valid_o, retire_id_o); else pass_cnt++;
        dc_req_ready_i = 1'b0;
        tick();
        total_cnt++; if (retire_seen - r0 !== 9) $display("FAIL b2b_retire_count got %0d exp 9", retire_seen - r0); else pass_cnt++;
    endtask

    initial begin
        rst = 1'b0;
        sq_valid_i = 1'b0; sq_addr_i = '0; sq_data_i = '0; sq_wstrb_i = '0;
        sq_id_i = '0; sq_uncached_i = 1'b0;
        dc_req_ready_i = 1'b0; dc_resp_valid_i = 1'b0; dc_resp_miss_i = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_replay();
        test_zero_strobe();
        test_reset_mid_wait();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
